// File: rtl/icache_pkg.sv
// Shared definitions for the set-associative instruction cache.
// Holds the bus widths, the refill FSM state encoding and the
// address-field width helpers used by icache_sa and icache_way.
package icache_pkg;

  localparam int unsigned WORD_W = 32;
  localparam int unsigned ADDR_W = 32;

  // Refill controller states
  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_BUSY    = 2'd1,
    ST_DISCARD = 2'd2
  } state_t;

  // Word-offset field width inside a line
  function automatic int unsigned off_w(input int unsigned line_words);
    return $clog2(line_words);
  endfunction

  // Set-index field width
  function automatic int unsigned idx_w(input int unsigned sets);
    return $clog2(sets);
  endfunction

  // Tag field width: whatever is left above index, offset and byte bits
  function automatic int unsigned tag_w(input int unsigned sets,
                                        input int unsigned line_words);
    return ADDR_W - idx_w(sets) - off_w(line_words) - 2;
  endfunction

endpackage

// File: rtl/icache_way.sv
// One way of the instruction cache: per-set valid flops, tag and data
// arrays, tag compare and word select for the lookup port, plus the
// single line write port used by refill.
//
// Ports:
//   clk, rst     clock, synchronous active-high reset (valid bits only)
//   rsy          global ready; low freezes all updates
//   flush        clear every valid bit at the next edge
//   rd_idx/tag/off  lookup address fields
//   hit_c        combinational: selected set is valid with matching tag
//   word_c       combinational: addressed word on hit, zero otherwise
//   wr_en        install wr_line/wr_tag into set wr_idx
module icache_way
  import icache_pkg::*;
#(
  parameter int unsigned SETS       = 128,
  parameter int unsigned LINE_WORDS = 4
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic                                   rsy,
  input  logic                                   flush,
  input  logic [idx_w(SETS)-1:0]                 rd_idx,
  input  logic [tag_w(SETS, LINE_WORDS)-1:0]     rd_tag,
  input  logic [off_w(LINE_WORDS)-1:0]           rd_off,
  output logic                                   hit_c,
  output logic [WORD_W-1:0]                      word_c,
  input  logic                                   wr_en,
  input  logic [idx_w(SETS)-1:0]                 wr_idx,
  input  logic [tag_w(SETS, LINE_WORDS)-1:0]     wr_tag,
  input  logic [LINE_WORDS*WORD_W-1:0]           wr_line
);

  localparam int unsigned TAG_W = tag_w(SETS, LINE_WORDS);

  logic [SETS-1:0]                    valid;
  logic [TAG_W-1:0]                   tag_mem  [SETS];
  logic [LINE_WORDS-1:0][WORD_W-1:0]  data_mem [SETS];

  // Valid bits: flush wins over a same-cycle install
  always_ff @(posedge clk) begin
    if (rst) begin
      valid <= '0;
    end else if (rsy) begin
      if (flush) begin
        valid <= '0;
      end else if (wr_en) begin
        valid[wr_idx] <= 1'b1;
      end
    end
  end

  // Tag and data arrays carry no reset; the valid bit qualifies them
  always_ff @(posedge clk) begin
    if (!rst && rsy && wr_en) begin
      tag_mem[wr_idx]  <= wr_tag;
      data_mem[wr_idx] <= wr_line;
    end
  end

  // Lookup
  assign hit_c  = valid[rd_idx] && (tag_mem[rd_idx] == rd_tag);
  assign word_c = hit_c ? data_mem[rd_idx][rd_off] : '0;

endmodule

// File: rtl/icache_sa.sv
// Set-associative instruction cache between fetch and the memory
// controller. Hits are answered combinationally; a miss issues one
// line refill, installed into a per-set round-robin victim way.
//
// Ports:
//   clk, rst           clock, synchronous active-high reset
//   rsy                global ready; low freezes all state
//   cache_en           enables lookups and miss issue
//   cache_st           stall: blocks miss issue and counter updates
//   cache_rb           rollback: forces if_cache_hit low
//   cache_flush        invalidate all lines
//   if_addr            fetch byte address
//   if_cache_hit       addressed word present (combinational)
//   if_hit_word        addressed word (combinational)
//   mem_ena, mem_addr  refill request, held until mem_valid
//   mem_valid, mem_line  refill response
//   hit_cnt, miss_cnt  performance counters
module icache_sa
  import icache_pkg::*;
#(
  parameter int unsigned SETS       = 128,
  parameter int unsigned WAYS       = 2,
  parameter int unsigned LINE_WORDS = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          rsy,
  input  logic                          cache_en,
  input  logic                          cache_st,
  input  logic                          cache_rb,
  input  logic                          cache_flush,
  input  logic [ADDR_W-1:0]             if_addr,
  output logic                          if_cache_hit,
  output logic [WORD_W-1:0]             if_hit_word,
  output logic                          mem_ena,
  output logic [ADDR_W-1:0]             mem_addr,
  input  logic                          mem_valid,
  input  logic [WORD_W*LINE_WORDS-1:0]  mem_line,
  output logic [31:0]                   hit_cnt,
  output logic [31:0]                   miss_cnt
);

  localparam int unsigned OFF_W = off_w(LINE_WORDS);
  localparam int unsigned IDX_W = idx_w(SETS);
  localparam int unsigned TAG_W = tag_w(SETS, LINE_WORDS);
  localparam int unsigned LSB_W = OFF_W + 2;
  localparam int unsigned WAY_W = (WAYS > 1) ? $clog2(WAYS) : 1;
  localparam int unsigned CNT_W = 32;

  // Lookup address fields
  logic [OFF_W-1:0] rd_off;
  logic [IDX_W-1:0] rd_idx;
  logic [TAG_W-1:0] rd_tag;
  logic             unused_addr_bits;

  assign rd_off           = if_addr[LSB_W-1:2];
  assign rd_idx           = if_addr[LSB_W +: IDX_W];
  assign rd_tag           = if_addr[ADDR_W-1 -: TAG_W];
  assign unused_addr_bits = ^if_addr[1:0];

  // Fill target comes from the latched request address, never if_addr
  logic [IDX_W-1:0] fill_idx;
  logic [TAG_W-1:0] fill_tag;

  assign fill_idx = mem_addr[LSB_W +: IDX_W];
  assign fill_tag = mem_addr[ADDR_W-1 -: TAG_W];

  state_t             state;
  state_t             state_d;
  logic               mem_ena_d;
  logic [ADDR_W-1:0]  mem_addr_d;
  logic [WAY_W-1:0]   fill_way;
  logic [WAY_W-1:0]   fill_way_d;
  logic               fill_we;
  logic               miss_go;
  logic               miss_inc;
  logic               hit_inc;
  logic [WAY_W-1:0]   rr [SETS];

  // Way array; matching words are OR-combined since at most one way hits
  logic [WAYS-1:0]              way_hit;
  logic [WAYS:0][WORD_W-1:0]    word_or;
  logic                         any_hit;

  assign word_or[0] = '0;

  for (genvar w = 0; w < WAYS; w++) begin : g_way
    logic              way_we;
    logic [WORD_W-1:0] way_word;

    assign way_we       = fill_we && (fill_way == WAY_W'(w));
    assign word_or[w+1] = word_or[w] | way_word;

    icache_way #(
      .SETS       (SETS),
      .LINE_WORDS (LINE_WORDS)
    ) u_way (
      .clk     (clk),
      .rst     (rst),
      .rsy     (rsy),
      .flush   (cache_flush),
      .rd_idx  (rd_idx),
      .rd_tag  (rd_tag),
      .rd_off  (rd_off),
      .hit_c   (way_hit[w]),
      .word_c  (way_word),
      .wr_en   (way_we),
      .wr_idx  (fill_idx),
      .wr_tag  (fill_tag),
      .wr_line (mem_line)
    );
  end

  assign any_hit      = |way_hit;
  assign if_cache_hit = any_hit && cache_en && !cache_rb && !rst;
  assign if_hit_word  = word_or[WAYS];

  assign miss_go = cache_en && !cache_st && !cache_rb && !cache_flush && !any_hit;
  assign hit_inc = if_cache_hit && !cache_st;

  // State and request registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_IDLE;
      mem_ena  <= 1'b0;
      mem_addr <= '0;
      fill_way <= '0;
    end else if (rsy) begin
      state    <= state_d;
      mem_ena  <= mem_ena_d;
      mem_addr <= mem_addr_d;
      fill_way <= fill_way_d;
    end
  end

  // Next state; a flush during a refill turns it into a discard
  always_comb begin
    state_d = state;
    unique case (state)
      ST_IDLE: begin
        if (miss_go) state_d = ST_BUSY;
      end
      ST_BUSY: begin
        if (mem_valid)        state_d = ST_IDLE;
        else if (cache_flush) state_d = ST_DISCARD;
      end
      ST_DISCARD: begin
        if (mem_valid) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Request, victim latch and install strobes
  always_comb begin
    mem_ena_d  = mem_ena;
    mem_addr_d = mem_addr;
    fill_way_d = fill_way;
    fill_we    = 1'b0;
    miss_inc   = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (miss_go) begin
          mem_ena_d  = 1'b1;
          mem_addr_d = {if_addr[ADDR_W-1:LSB_W], {LSB_W{1'b0}}};
          fill_way_d = rr[rd_idx];
          miss_inc   = 1'b1;
        end
      end
      ST_BUSY: begin
        if (mem_valid) begin
          mem_ena_d = 1'b0;
          fill_we   = !cache_flush;
        end
      end
      ST_DISCARD: begin
        if (mem_valid) mem_ena_d = 1'b0;
      end
      default: mem_ena_d = 1'b0;
    endcase
  end

  // Round-robin victim pointers advance only on a real install
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned s = 0; s < SETS; s++) begin
        rr[IDX_W'(s)] <= '0;
      end
    end else if (rsy && fill_we) begin
      if (rr[fill_idx] == WAY_W'(WAYS - 1)) begin
        rr[fill_idx] <= '0;
      end else begin
        rr[fill_idx] <= rr[fill_idx] + WAY_W'(1);
      end
    end
  end

  // Performance counters, wrapping
  always_ff @(posedge clk) begin
    if (rst) begin
      hit_cnt  <= '0;
      miss_cnt <= '0;
    end else if (rsy) begin
      if (hit_inc)  hit_cnt  <= hit_cnt  + CNT_W'(1);
      if (miss_inc) miss_cnt <= miss_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_icache_sa.sv
// Directed bench for icache_sa with a cache model kept at the level of
// "which lines are resident in which set" and one outstanding request.
module tb_icache_sa;

  localparam int unsigned SETS = 128;
  localparam int unsigned WAYS = 2;
  localparam int unsigned LW   = 4;
  localparam int unsigned OFFB = $clog2(LW);
  localparam int unsigned IDXB = $clog2(SETS);

  logic              clk         = 1'b0;
  logic              rst         = 1'b1;
  logic              rsy         = 1'b1;
  logic              cache_en    = 1'b0;
  logic              cache_st    = 1'b0;
  logic              cache_rb    = 1'b0;
  logic              cache_flush = 1'b0;
  logic [31:0]       if_addr     = '0;
  logic              mem_valid   = 1'b0;
  logic [32*LW-1:0]  mem_line    = '0;
  logic              if_cache_hit;
  logic [31:0]       if_hit_word;
  logic              mem_ena;
  logic [31:0]       mem_addr;
  logic [31:0]       hit_cnt;
  logic [31:0]       miss_cnt;

  icache_sa #(.SETS(SETS), .WAYS(WAYS), .LINE_WORDS(LW)) dut (
    .clk          (clk),
    .rst          (rst),
    .rsy          (rsy),
    .cache_en     (cache_en),
    .cache_st     (cache_st),
    .cache_rb     (cache_rb),
    .cache_flush  (cache_flush),
    .if_addr      (if_addr),
    .if_cache_hit (if_cache_hit),
    .if_hit_word  (if_hit_word),
    .mem_ena      (mem_ena),
    .mem_addr     (mem_addr),
    .mem_valid    (mem_valid),
    .mem_line     (mem_line),
    .hit_cnt      (hit_cnt),
    .miss_cnt     (miss_cnt)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- backing memory contents ----------------
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'h0000_1004) return 32'hDEAD_BEEF;
    return a ^ 32'hA5A5_0000;
  endfunction

  function automatic logic [31:0] line_base(input logic [31:0] a);
    return a & ~32'(LW * 4 - 1);
  endfunction

  function automatic logic [32*LW-1:0] make_line(input logic [31:0] base);
    logic [32*LW-1:0] l;
    for (int k = 0; k < LW; k++) l[32*k +: 32] = mem_word(base + 32'(4 * k));
    return l;
  endfunction

  // ---------------- model ----------------
  bit          m_valid [SETS][WAYS];
  logic [31:0] m_tag   [SETS][WAYS];
  logic [31:0] m_data  [SETS][WAYS][LW];
  int unsigned m_rr    [SETS];
  bit          m_ena   = 1'b0;
  bit          m_drop  = 1'b0;
  logic [31:0] m_addr  = '0;
  int unsigned m_victim = 0;
  logic [31:0] m_hc    = '0;
  logic [31:0] m_mc    = '0;

  function automatic int unsigned set_of(input logic [31:0] a);
    return (a >> (OFFB + 2)) % SETS;
  endfunction

  function automatic logic [31:0] tag_of(input logic [31:0] a);
    return a >> (OFFB + 2 + IDXB);
  endfunction

  function automatic int unsigned word_of(input logic [31:0] a);
    return (a >> 2) % LW;
  endfunction

  function automatic bit m_present(input logic [31:0] a, output logic [31:0] w);
    bit p = 1'b0;
    w = '0;
    for (int k = 0; k < WAYS; k++) begin
      if (m_valid[set_of(a)][k] && m_tag[set_of(a)][k] == tag_of(a)) begin
        p = 1'b1;
        w = m_data[set_of(a)][k][word_of(a)];
      end
    end
    return p;
  endfunction

  task automatic model_step();
    logic [31:0] w;
    bit          pres;
    int unsigned s;
    if (rst) begin
      for (int i = 0; i < SETS; i++) begin
        m_rr[i] = 0;
        for (int j = 0; j < WAYS; j++) m_valid[i][j] = 1'b0;
      end
      m_ena = 1'b0; m_drop = 1'b0; m_addr = '0; m_hc = '0; m_mc = '0;
    end else if (rsy) begin
      pres = m_present(if_addr, w);
      if (pres && cache_en && !cache_rb && !cache_st) m_hc = m_hc + 32'd1;
      if (m_ena) begin
        if (cache_flush) m_drop = 1'b1;
        if (mem_valid) begin
          if (!m_drop) begin
            s = set_of(m_addr);
            m_valid[s][m_victim] = 1'b1;
            m_tag[s][m_victim]   = tag_of(m_addr);
            for (int k = 0; k < LW; k++) m_data[s][m_victim][k] = mem_line[32*k +: 32];
            m_rr[s] = (m_rr[s] + 1) % WAYS;
          end
          m_ena = 1'b0; m_drop = 1'b0;
        end
      end else if (!pres && cache_en && !cache_st && !cache_rb && !cache_flush) begin
        m_ena    = 1'b1;
        m_drop   = 1'b0;
        m_addr   = line_base(if_addr);
        m_victim = m_rr[set_of(if_addr)];
        m_mc     = m_mc + 32'd1;
      end
      if (cache_flush) begin
        for (int i = 0; i < SETS; i++)
          for (int j = 0; j < WAYS; j++) m_valid[i][j] = 1'b0;
      end
    end
  endtask

  task automatic compare_step();
    logic [31:0] w;
    bit          pres;
    bit          exp_hit;
    pres    = m_present(if_addr, w);
    exp_hit = pres && cache_en && !cache_rb && !rst;
    check("hit", 32'(if_cache_hit), 32'(exp_hit));
    if (exp_hit)   check("hit_word", if_hit_word, w);
    else if (!pres) check("miss_word_zero", if_hit_word, 32'h0);
    check("mem_ena", 32'(mem_ena), 32'(m_ena));
    if (m_ena) check("mem_addr", mem_addr, m_addr);
    check("hit_cnt", hit_cnt, m_hc);
    check("miss_cnt", miss_cnt, m_mc);
  endtask

  initial forever begin
    @(posedge clk);
    model_step();
  end

  initial forever begin
    @(negedge clk);
    compare_step();
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; rsy = 1'b1; cache_en = 1'b0; cache_st = 1'b0;
    cache_rb = 1'b0; cache_flush = 1'b0; mem_valid = 1'b0;
    tick(); tick();
    rst = 1'b0;
  endtask

  // Miss on a, answer after lat extra cycles; ends in a stalled posture
  task automatic fill(input logic [31:0] a, input int lat, input bit st_at_valid);
    if_addr = a; cache_en = 1'b1; cache_st = 1'b0; cache_rb = 1'b0;
    tick();
    repeat (lat) tick();
    mem_valid = 1'b1;
    mem_line  = make_line(line_base(a));
    cache_st  = st_at_valid;
    @(negedge clk);
    check("req_ena", 32'(mem_ena), 32'd1);
    check("req_addr", mem_addr, line_base(a));
    tick();
    mem_valid = 1'b0;
    cache_st  = 1'b1;
    @(negedge clk);
    check("fill_hit", 32'(if_cache_hit), 32'd1);
    check("fill_ena_low", 32'(mem_ena), 32'd0);
    tick();
  endtask

  task automatic probe(input string name, input logic [31:0] a, input bit exp);
    cache_st = 1'b1; cache_en = 1'b1; cache_rb = 1'b0;
    if_addr  = a;
    @(negedge clk);
    check(name, 32'(if_cache_hit), 32'(exp));
    tick();
  endtask

  initial begin
    // Reset state
    rst = 1'b1;
    repeat (3) tick();
    @(negedge clk);
    check("rst_mem_ena", 32'(mem_ena), 32'd0);
    check("rst_hit_cnt", hit_cnt, 32'd0);
    check("rst_miss_cnt", miss_cnt, 32'd0);
    tick();
    rst = 1'b0;

    // Cold miss at 0x1004
    fill(32'h0000_1004, 2, 1'b0);
    @(negedge clk);
    check("cold_word", if_hit_word, 32'hDEAD_BEEF);
    check("cold_miss_cnt", miss_cnt, 32'd1);
    check("cold_hit_cnt", hit_cnt, 32'd0);
    tick();
    probe("cold_last_word", 32'h0000_100C, 1'b1);

    // Two-way eviction in set 0
    do_reset();
    fill(32'h0000_0000, 1, 1'b0);
    fill(32'h0000_0800, 0, 1'b0);
    probe("both_a", 32'h0000_0000, 1'b1);
    probe("both_b", 32'h0000_0804, 1'b1);
    fill(32'h0000_1000, 3, 1'b0);
    probe("evicted_way0", 32'h0000_0000, 1'b0);
    probe("kept_way1", 32'h0000_0800, 1'b1);
    probe("new_line", 32'h0000_1008, 1'b1);
    @(negedge clk);
    check("evict_miss_cnt", miss_cnt, 32'd3);
    tick();

    // Stall across the refill response
    fill(32'h0000_2000, 2, 1'b1);
    probe("stall_installed", 32'h0000_2004, 1'b1);
    @(negedge clk);
    check("stall_miss_cnt", miss_cnt, 32'd4);
    check("stall_hit_cnt", hit_cnt, 32'd0);
    tick();

    // Flush while busy, line arrives later
    if_addr = 32'h0000_3000; cache_en = 1'b1; cache_st = 1'b0;
    tick();
    cache_flush = 1'b1;
    tick();
    cache_flush = 1'b0;
    tick();
    mem_valid = 1'b1; mem_line = make_line(32'h0000_3000);
    tick();
    mem_valid = 1'b0; cache_st = 1'b1;
    @(negedge clk);
    check("discard_ena", 32'(mem_ena), 32'd0);
    tick();
    probe("discard_none", 32'h0000_3000, 1'b0);
    probe("flushed_a", 32'h0000_1000, 1'b0);
    probe("flushed_b", 32'h0000_2000, 1'b0);
    fill(32'h0000_3000, 1, 1'b0);

    // Flush and response in the same busy cycle
    if_addr = 32'h0000_4040; cache_en = 1'b1; cache_st = 1'b0;
    tick();
    mem_valid = 1'b1; cache_flush = 1'b1; mem_line = make_line(32'h0000_4040);
    tick();
    mem_valid = 1'b0; cache_flush = 1'b0; cache_st = 1'b1;
    @(negedge clk);
    check("flush_valid_ena", 32'(mem_ena), 32'd0);
    tick();
    probe("flush_valid_none", 32'h0000_4040, 1'b0);
    probe("flush_valid_old", 32'h0000_3000, 1'b0);
    @(negedge clk);
    check("flush_miss_cnt", miss_cnt, 32'd7);
    tick();

    // Rollback on a hitting address
    do_reset();
    fill(32'h0000_0040, 0, 1'b0);
    cache_st = 1'b0; cache_rb = 1'b1; if_addr = 32'h0000_0044;
    @(negedge clk);
    check("rb_hit_low", 32'(if_cache_hit), 32'd0);
    tick();
    @(negedge clk);
    check("rb_hit_cnt", hit_cnt, 32'd0);
    tick();
    cache_rb = 1'b0;
    @(negedge clk);
    check("rb_release_hit", 32'(if_cache_hit), 32'd1);
    tick();
    cache_st = 1'b1;
    @(negedge clk);
    check("rb_release_cnt", hit_cnt, 32'd1);
    tick();

    // Reset in the middle of a refill
    if_addr = 32'h0000_0080; cache_en = 1'b1; cache_st = 1'b0;
    tick();
    rst = 1'b1;
    @(negedge clk);
    check("rst_pending_ena", 32'(mem_ena), 32'd1);
    tick();
    rst = 1'b0; cache_st = 1'b1;
    @(negedge clk);
    check("rst_mid_ena", 32'(mem_ena), 32'd0);
    tick();
    probe("rst_cleared", 32'h0000_0040, 1'b0);
    mem_valid = 1'b1; mem_line = make_line(32'h0000_0080);
    tick();
    mem_valid = 1'b0;
    probe("stray_ignored", 32'h0000_0080, 1'b0);

    // Global ready low freezes a response
    if_addr = 32'h0000_00C0; cache_en = 1'b1; cache_st = 1'b0;
    tick();
    rsy = 1'b0; mem_valid = 1'b1; mem_line = make_line(32'h0000_00C0);
    tick();
    rsy = 1'b1; mem_valid = 1'b0;
    @(negedge clk);
    check("freeze_ena", 32'(mem_ena), 32'd1);
    tick();
    mem_valid = 1'b1;
    tick();
    mem_valid = 1'b0; cache_st = 1'b1;
    @(negedge clk);
    check("thaw_hit", 32'(if_cache_hit), 32'd1);
    check("thaw_word", if_hit_word, 32'hA5A5_00C0);
    check("thaw_miss_cnt", miss_cnt, 32'd1);
    tick();

    repeat (2) tick();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
